// File: rtl/bin_2_gray_counter_pkg.sv
// ============================================================================
// Module      : bin_2_gray_counter_pkg
// Description : Shared width default and step-action encoding for the
//               binary/Gray pointer counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bin_2_gray_counter_pkg;

    // Kept equal to the Gray-to-binary decoder width so pointer pairs match.
    localparam int DEFAULT_WIDTH = 5;

    typedef enum logic [1:0] {
        ACT_HOLD = 2'd0,
        ACT_LOAD = 2'd1,
        ACT_UP   = 2'd2,
        ACT_DOWN = 2'd3
    } step_act_e;

endpackage : bin_2_gray_counter_pkg

`default_nettype wire

// File: rtl/bin_2_gray.sv
// ============================================================================
// Module      : bin_2_gray
// Description : Combinational reflected-binary (Gray) encoder; inverse of the
//               Gray-to-binary decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin_2_gray
    import bin_2_gray_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule : bin_2_gray

`default_nettype wire

// File: rtl/bin_2_gray_counter.sv
// ============================================================================
// Module      : bin_2_gray_counter
// Description : Registered up/down counter presenting each count as binary and
//               as Gray code, with wrap and changed pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin_2_gray_counter
    import bin_2_gray_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             wrap,
    output logic             changed
);

    localparam logic [WIDTH-1:0] C_ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] C_ALL_ONES = '1;
    localparam logic [WIDTH-1:0] C_ZERO     = '0;

    step_act_e        w_act;
    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] bin_d;
    logic [WIDTH-1:0] gray_q;
    logic [WIDTH-1:0] gray_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             changed_q;
    logic             changed_d;

    always_comb begin
        w_act = ACT_HOLD;
        if (load) begin
            w_act = ACT_LOAD;
        end else if (en) begin
            w_act = up_dn ? ACT_UP : ACT_DOWN;
        end
    end

    always_comb begin
        bin_d     = bin_q;
        wrap_d    = 1'b0;
        changed_d = 1'b0;
        case (w_act)
            ACT_LOAD: begin
                bin_d     = load_bin;
                changed_d = 1'b1;
            end
            ACT_UP: begin
                bin_d     = bin_q + C_ONE;
                wrap_d    = (bin_q == C_ALL_ONES);
                changed_d = 1'b1;
            end
            ACT_DOWN: begin
                bin_d     = bin_q - C_ONE;
                wrap_d    = (bin_q == C_ZERO);
                changed_d = 1'b1;
            end
            default: begin
                bin_d     = bin_q;
                wrap_d    = 1'b0;
                changed_d = 1'b0;
            end
        endcase
    end

    // Encode the next value so binary and Gray registers update on the same edge.
    bin_2_gray #(
        .WIDTH (WIDTH)
    ) u_bin_2_gray (
        .bin  (bin_d),
        .gray (gray_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q     <= '0;
            gray_q    <= '0;
            wrap_q    <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            bin_q     <= bin_d;
            gray_q    <= gray_d;
            wrap_q    <= wrap_d;
            changed_q <= changed_d;
        end
    end

    assign bin_out  = bin_q;
    assign gray_out = gray_q;
    assign wrap     = wrap_q;
    assign changed  = changed_q;

endmodule : bin_2_gray_counter

`default_nettype wire

// File: tb/tb_bin_2_gray_counter.sv
// ============================================================================
// Module      : tb_bin_2_gray_counter
// Description : Scoreboard bench for bin_2_gray_counter (WIDTH=5).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bin_2_gray_counter;

    localparam int WIDTH = 5;

    typedef struct {
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] g;
        logic             w;
        logic             c;
        logic             step;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_bin;
    logic [WIDTH-1:0] bin_out;
    logic [WIDTH-1:0] gray_out;
    logic             wrap;
    logic             changed;

    exp_t             sb_q[$];
    logic [WIDTH-1:0] gtab [32];
    logic [WIDTH-1:0] m_bin;
    logic [WIDTH-1:0] prev_gray;
    int               n_checks;
    int               n_errors;

    bin_2_gray_counter #(
        .WIDTH (WIDTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up_dn    (up_dn),
        .load     (load),
        .load_bin (load_bin),
        .bin_out  (bin_out),
        .gray_out (gray_out),
        .wrap     (wrap),
        .changed  (changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    task automatic push_exp(input logic [WIDTH-1:0] eb, input logic [WIDTH-1:0] eg,
                            input logic ew, input logic ec, input logic st);
        exp_t e;
        e.b = eb; e.g = eg; e.w = ew; e.c = ec; e.step = st;
        sb_q.push_back(e);
    endtask

    task automatic apply(input logic r, input logic l, input logic e, input logic u,
                         input logic [WIDTH-1:0] lb);
        @(negedge clk);
        rst = r; load = l; en = e; up_dn = u; load_bin = lb;
    endtask

    // Directed step: expected values written out by hand.
    task automatic drive_h(input logic r, input logic l, input logic e, input logic u,
                           input logic [WIDTH-1:0] lb, input logic [WIDTH-1:0] eb,
                           input logic [WIDTH-1:0] eg, input logic ew, input logic ec);
        apply(r, l, e, u, lb);
        push_exp(eb, eg, ew, ec, !r && !l && e);
        m_bin = eb;
    endtask

    // Model-driven step for the random phase; Gray comes from the hand table.
    task automatic drive_m(input logic r, input logic l, input logic e, input logic u,
                           input logic [WIDTH-1:0] lb);
        logic [WIDTH-1:0] nb;
        logic             w;
        logic             c;
        nb = m_bin; w = 1'b0; c = 1'b0;
        if (r) begin
            nb = '0;
        end else if (l) begin
            nb = lb; c = 1'b1;
        end else if (e) begin
            c = 1'b1;
            if (u) begin
                w  = (m_bin == 5'd31);
                nb = (m_bin == 5'd31) ? 5'd0 : m_bin + 5'd1;
            end else begin
                w  = (m_bin == 5'd0);
                nb = (m_bin == 5'd0) ? 5'd31 : m_bin - 5'd1;
            end
        end
        apply(r, l, e, u, lb);
        push_exp(nb, gtab[nb], w, c, !r && !l && e);
        m_bin = nb;
    endtask

    // Monitor: one expected entry per clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("bin_out",  int'(bin_out),  int'(e.b));
                chk("gray_out", int'(gray_out), int'(e.g));
                chk("wrap",     int'(wrap),     int'(e.w));
                chk("changed",  int'(changed),  int'(e.c));
                chk("round_trip", int'(g2b(gray_out)), int'(bin_out));
                if (e.step) chk("gray_hamming", $countones(gray_out ^ prev_gray), 1);
                prev_gray = gray_out;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running, required done");
        $fatal(1, "timeout");
    end

    initial begin
        gtab = '{5'h00, 5'h01, 5'h03, 5'h02, 5'h06, 5'h07, 5'h05, 5'h04,
                 5'h0C, 5'h0D, 5'h0F, 5'h0E, 5'h0A, 5'h0B, 5'h09, 5'h08,
                 5'h18, 5'h19, 5'h1B, 5'h1A, 5'h1E, 5'h1F, 5'h1D, 5'h1C,
                 5'h14, 5'h15, 5'h17, 5'h16, 5'h12, 5'h13, 5'h11, 5'h10};
        n_checks = 0; n_errors = 0; m_bin = '0; prev_gray = '0;
        rst = 1'b1; load = 1'b1; en = 1'b1; up_dn = 1'b1; load_bin = 5'b10110;

        // Reset overrides load and en.
        repeat (2) drive_h(1, 1, 1, 1, 5'b10110, 5'b00000, 5'b00000, 0, 0);

        // Full up-count cycle; wrap only on 31 -> 0.
        for (int k = 1; k <= 32; k++)
            drive_h(0, 0, 1, 1, 5'd0, 5'(k % 32), gtab[k % 32], (k == 32), 1);

        // Down through zero.
        drive_h(0, 1, 0, 0, 5'b00001, 5'b00001, 5'b00001, 0, 1);
        drive_h(0, 0, 1, 0, 5'd0,     5'b00000, 5'b00000, 0, 1);
        drive_h(0, 0, 1, 0, 5'd0,     5'b11111, 5'b10000, 1, 1);
        drive_h(0, 0, 1, 0, 5'd0,     5'b11110, 5'b10001, 0, 1);

        // Load wins over en.
        drive_h(0, 1, 1, 1, 5'b01010, 5'b01010, 5'b01111, 0, 1);
        drive_h(0, 0, 1, 1, 5'd0,     5'b01011, 5'b01110, 0, 1);

        // Hold, then direction reversal each cycle.
        drive_h(0, 1, 0, 0, 5'b00101, 5'b00101, 5'b00111, 0, 1);
        repeat (3) drive_h(0, 0, 0, 1, 5'd0, 5'b00101, 5'b00111, 0, 0);
        drive_h(0, 0, 1, 1, 5'd0, 5'b00110, 5'b00101, 0, 1);
        drive_h(0, 0, 1, 0, 5'd0, 5'b00101, 5'b00111, 0, 1);
        drive_h(0, 0, 1, 1, 5'd0, 5'b00110, 5'b00101, 0, 1);

        // Loads of all-ones and zero never raise wrap.
        drive_h(0, 1, 1, 0, 5'b11111, 5'b11111, 5'b10000, 0, 1);
        drive_h(0, 1, 1, 1, 5'b00000, 5'b00000, 5'b00000, 0, 1);
        drive_h(0, 0, 1, 1, 5'd0,     5'b00001, 5'b00001, 0, 1);

        // Reset in the middle of counting.
        drive_h(1, 1, 1, 1, 5'b10101, 5'b00000, 5'b00000, 0, 0);

        // Random traffic with round-trip decode on every cycle.
        for (int i = 0; i < 1000; i++)
            drive_m(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 3) != 0), 1'($urandom), 5'($urandom));

        apply(0, 0, 0, 0, 5'd0);
        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_bin_2_gray_counter

`default_nettype wire
